// File: rtl/cx_stream_upsizer.sv
// cx_stream_upsizer: packs RATIO narrow stream beats into one wide word and
// queues finished words in a small output FIFO. Words close early on tlast
// or when tid changes mid-word; unfilled lanes go out as zero data/strobe.
module cx_stream_upsizer #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned RATIO      = 4,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    input  logic [IN_WIDTH-1:0]                  s_tdata,
    input  logic [IN_WIDTH/8-1:0]                s_tstrb,
    input  logic                                 s_tlast,
    input  logic [ID_WIDTH-1:0]                  s_tid,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [IN_WIDTH*RATIO-1:0]            m_tdata,
    output logic [IN_WIDTH*RATIO/8-1:0]          m_tstrb,
    output logic                                 m_tlast,
    output logic [ID_WIDTH-1:0]                  m_tid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

    localparam int unsigned IN_STRB   = IN_WIDTH / 8;
    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned OUT_STRB  = OUT_WIDTH / 8;
    localparam int unsigned LANE_W    = $clog2(RATIO);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

    // Packer state
    logic [LANE_W-1:0]                  lane_cnt_q, lane_cnt_d;
    logic [ID_WIDTH-1:0]                cur_id_q, cur_id_d;
    logic [RATIO-1:0][IN_WIDTH-1:0]     lane_data_q, lane_data_d;
    logic [RATIO-1:0][IN_STRB-1:0]      lane_strb_q, lane_strb_d;

    // FIFO state
    logic [FIFO_DEPTH-1:0][OUT_WIDTH-1:0] mem_data_q;
    logic [FIFO_DEPTH-1:0][OUT_STRB-1:0]  mem_strb_q;
    logic [FIFO_DEPTH-1:0]                mem_last_q;
    logic [FIFO_DEPTH-1:0][ID_WIDTH-1:0]  mem_id_q;
    logic [PTR_W-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                     count_q, count_d;

    // Handshake and word-assembly signals
    logic                               full_c, flush_c, flush_push_c;
    logic                               accept_c, complete_c, push_c, pop_c;
    logic [RATIO-1:0][IN_WIDTH-1:0]     word_data_c;
    logic [RATIO-1:0][IN_STRB-1:0]      word_strb_c;
    logic                               word_last_c;
    logic [ID_WIDTH-1:0]                word_id_c;

    // Flow control: full comes from the registered count only
    always_comb begin
        full_c       = (count_q == CNT_W'(FIFO_DEPTH));
        flush_c      = s_tvalid && (lane_cnt_q != '0) && (s_tid != cur_id_q);
        flush_push_c = flush_c && !full_c;
        s_tready     = !rst && !full_c && !flush_c;
        accept_c     = s_tvalid && s_tready;
        complete_c   = accept_c && (s_tlast || (lane_cnt_q == LANE_W'(RATIO - 1)));
        push_c       = complete_c || flush_push_c;
        m_tvalid     = (count_q != '0);
        pop_c        = m_tvalid && m_tready;
    end

    // Word assembly: filled lanes from buffers, current beat in its lane, rest zero
    always_comb begin
        word_data_c = '0;
        word_strb_c = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) < lane_cnt_q) begin
                word_data_c[i] = lane_data_q[i];
                word_strb_c[i] = lane_strb_q[i];
            end else if (accept_c && (LANE_W'(i) == lane_cnt_q)) begin
                word_data_c[i] = s_tdata;
                word_strb_c[i] = s_tstrb;
            end
        end
        word_last_c = complete_c && s_tlast;
        word_id_c   = (lane_cnt_q == '0) ? s_tid : cur_id_q;
    end

    // Packer next state
    always_comb begin
        lane_cnt_d  = lane_cnt_q;
        cur_id_d    = cur_id_q;
        lane_data_d = lane_data_q;
        lane_strb_d = lane_strb_q;
        if (accept_c && (lane_cnt_q == '0)) begin
            cur_id_d = s_tid;
        end
        if (push_c) begin
            lane_cnt_d = '0;
        end else if (accept_c) begin
            lane_data_d[lane_cnt_q] = s_tdata;
            lane_strb_d[lane_cnt_q] = s_tstrb;
            lane_cnt_d              = lane_cnt_q + LANE_W'(1);
        end
    end

    // FIFO pointer/count next state
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Packer registers; reset discards any partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q  <= '0;
            cur_id_q    <= '0;
            lane_data_q <= '0;
            lane_strb_q <= '0;
        end else begin
            lane_cnt_q  <= lane_cnt_d;
            cur_id_q    <= cur_id_d;
            lane_data_q <= lane_data_d;
            lane_strb_q <= lane_strb_d;
        end
    end

    // FIFO storage and pointers; storage cleared so outputs read zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data_q <= '0;
            mem_strb_q <= '0;
            mem_last_q <= '0;
            mem_id_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (push_c) begin
                mem_data_q[wr_ptr_q] <= word_data_c;
                mem_strb_q[wr_ptr_q] <= word_strb_c;
                mem_last_q[wr_ptr_q] <= word_last_c;
                mem_id_q[wr_ptr_q]   <= word_id_c;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head entry drives the output stream
    always_comb begin
        m_tdata = mem_data_q[rd_ptr_q];
        m_tstrb = mem_strb_q[rd_ptr_q];
        m_tlast = mem_last_q[rd_ptr_q];
        m_tid   = mem_id_q[rd_ptr_q];
        count   = count_q;
    end

endmodule
